// File: rtl/data_buffer_pkg.sv
// Purpose: shared sizing helpers and constants for the delay-chain buffers.
// Latency: n/a (elaboration-time functions and constants only).
// Backpressure: n/a.
package data_buffer_pkg;

  // Default drop-counter width and its saturation value.
  localparam int DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_SAT = '1;

  // Pointer width with one extra wrap bit, so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two and at least 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that saturates at all-ones, with a synchronous clear.
// Latency: count updates 1 cycle after inc/clr.
// Backpressure: none; an increment arriving with clr still counts (result 1).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SAT = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Clear restarts the count; a coincident increment is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != SAT)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/data_rate_buffer.sv
// Purpose: buffers the free-running delay-chain word into a valid/ready stream, counts drops.
// Latency: a word pushed at edge N appears on o_valid/o_data after edge N; no bypass.
// Backpressure: none upstream; words arriving while full and not popping are dropped and counted.
module data_rate_buffer
  import data_buffer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = DROP_CNT_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic [CNT_WIDTH-1:0]       o_drop_count,
  input  logic                       i_clr
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Reject depths the wrap-bit pointer scheme cannot handle.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("data_rate_buffer: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    level;
  logic             overflow;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Occupancy flags and per-cycle transfer decisions.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = !empty && i_ready;
    // A full buffer still accepts a word when the head leaves the same cycle.
    push  = i_valid && (!full || pop);
    drop  = i_valid && full && !pop;
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointers wrap modulo 2*DEPTH through the extra MSB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Registered occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + PTR_ONE;
    end else if (pop && !push) begin
      level <= level - PTR_ONE;
    end
  end

  // Sticky overflow flag; a drop in the clear cycle keeps it set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (i_clr) begin
      overflow <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_drop_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (drop),
    .clr   (i_clr),
    .count (o_drop_count)
  );

  // Head entry is read straight from the registered array (first-word fall-through).
  always_comb begin
    o_valid    = !empty;
    o_data     = mem[rd_ptr[AW-1:0]];
    o_level    = level;
    o_overflow = overflow;
  end

endmodule

// File: tb/tb_data_rate_buffer.sv
// Purpose: self-checking bench for data_rate_buffer against a queue-based reference.
// Latency: model updates at each rising edge; outputs compared on the falling edge.
// Backpressure: the model applies the accept/drop rules to its own queue.
module tb_data_rate_buffer;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 16;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int CNT_MAX   = 65535;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic [WIDTH-1:0]     i_data;
  logic                 o_valid;
  logic [WIDTH-1:0]     o_data;
  logic                 i_ready;
  logic [LW-1:0]        o_level;
  logic                 o_overflow;
  logic [CNT_WIDTH-1:0] o_drop_count;
  logic                 i_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: buffered words in arrival order, sticky flag, drop count.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  int               m_cnt;

  data_rate_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_level      (o_level),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count),
    .i_clr        (i_clr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".valid"}, 64'(o_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check({ph, ".data"}, 64'(o_data), 64'(mq[0]));
    check({ph, ".level"}, 64'(o_level), 64'(mq.size()));
    check({ph, ".ovf"}, 64'(o_overflow), 64'(m_ovf));
    check({ph, ".cnt"}, 64'(o_drop_count), 64'(m_cnt));
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic c, input string ph);
    bit was_full, will_pop, will_push, will_drop;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_clr   = c;
    was_full  = (mq.size() == DEPTH);
    will_pop  = (mq.size() != 0) && r;
    will_push = v && (!was_full || will_pop);
    will_drop = v && was_full && !will_pop;
    @(posedge i_clk);
    if (will_pop)  void'(mq.pop_front());
    if (will_push) mq.push_back(d);
    if (c) begin
      m_ovf = will_drop;
      m_cnt = will_drop ? 1 : 0;
    end else if (will_drop) begin
      m_ovf = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    @(negedge i_clk);
    check_outputs(ph);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] first_word;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_outputs("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // 1: pass-through, one cycle latency, level never above 1.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'hA0 + i), 1'b1, 1'b0, "t1");
    cycle(1'b0, '0, 1'b1, 1'b0, "t1_drain");

    // 2: fill to DEPTH with the consumer stalled.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hB0 + i), 1'b0, 1'b0, "t2");
    first_word = 32'hB0;
    check("t2.full_level", 64'(o_level), 64'(DEPTH));
    check("t2.head", 64'(o_data), 64'(first_word));

    // 3: three drops, then drain in original order.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(32'hDD0 + i), 1'b0, 1'b0, "t3_drop");
    check("t3.drop_count", 64'(o_drop_count), 64'd3);
    check("t3.ovf", 64'(o_overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3.drain_order", 64'(o_data), 64'(32'hB0 + i));
      cycle(1'b0, '0, 1'b1, 1'b0, "t3_drain");
    end

    // 4: full buffer streaming through pointer wrap without drops.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hC0 + i), 1'b0, 1'b0, "t4_fill");
    for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'(32'hC8 + i), 1'b1, 1'b0, "t4_stream");
    check("t4.level", 64'(o_level), 64'(DEPTH));
    check("t4.no_new_drops", 64'(o_drop_count), 64'd3);

    // 5: clear and drop together, then saturate the counter.
    cycle(1'b1, 32'hEE, 1'b0, 1'b1, "t5_clr_drop");
    check("t5.clr_drop_cnt", 64'(o_drop_count), 64'd1);
    check("t5.clr_drop_ovf", 64'(o_overflow), 64'd1);
    for (int i = 0; i < CNT_MAX + 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, "t5_sat");
    check("t5.saturated", 64'(o_drop_count), 64'hFFFF);
    cycle(1'b0, '0, 1'b0, 1'b1, "t5_clr");
    check("t5.cleared", 64'(o_drop_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "t5_drain");

    // Randomized traffic with varying load and consumer rate.
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pr;
      pv = 30 + 20 * ph;
      pr = 90 - 20 * ph;
      for (int i = 0; i < 200; i++)
        cycle($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < 3, "rand");
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "rand_drain");

    // 6: asynchronous reset mid-drain with five words buffered.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'hF0 + i), 1'b0, 1'b0, "t6_fill");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "t6_pop");
    check("t6.level_before", 64'(o_level), 64'd5);
    i_ready = 1'b1;
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    check("t6.async_valid", 64'(o_valid), 64'd0);
    check("t6.async_level", 64'(o_level), 64'd0);
    @(negedge i_clk);
    check_outputs("t6_in_reset");
    i_rst = 1'b0;
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, "t6_push");
    check("t6.reappear", 64'(o_data), 64'h1234_5678);
    cycle(1'b0, '0, 1'b1, 1'b0, "t6_pop_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
